// File: rtl/arb_req_holder.sv
// arb_req_holder: requester-side holding slots for a fixed-priority arbiter.
// Each client owns one slot (EMPTY/PENDING + payload). The pending vector
// drives req_o into an external combinational arbiter; a legal one-hot grant
// moves the granted payload into a single registered valid/ready output stage.
// Optional starvation monitor enabled by defining ARB_REQ_HOLDER_STARVE_MON_EN.
module arb_req_holder #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ*DATA_W-1:0]  in_data_i,
    input  logic [NUM_REQ-1:0]         in_valid_i,
    output logic [NUM_REQ-1:0]         in_ready_o,
    output logic [NUM_REQ-1:0]         req_o,
    input  logic [NUM_REQ-1:0]         gnt_i,
    output logic [DATA_W-1:0]          out_data_o,
    output logic [$clog2(NUM_REQ)-1:0] out_idx_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       gnt_err_o,
    output logic [NUM_REQ-1:0]         starve_o
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] pend;
    logic [DATA_W-1:0]  slot_data [NUM_REQ];

    logic               out_free;
    logic               gnt_any;
    logic               gnt_onehot;
    logic               gnt_hits_empty;
    logic               gnt_legal;
    logic               gnt_illegal;
    logic               take;
    logic [NUM_REQ-1:0] take_vec;
    logic [NUM_REQ-1:0] gnt_m1;
    logic [IDX_W-1:0]   gnt_idx;
    logic [DATA_W-1:0]  gnt_data;

    // A slot accepts new data only while empty; pending slots are the requests.
    assign in_ready_o = ~pend;
    assign req_o      = pend;

    // Decode the grant: classify it, locate the selected slot, decide the transfer.
    always_comb begin
        gnt_m1         = gnt_i - NUM_REQ'(1);
        gnt_any        = |gnt_i;
        gnt_onehot     = gnt_any && ((gnt_i & gnt_m1) == '0);
        gnt_hits_empty = |(gnt_i & ~pend);
        gnt_legal      = gnt_onehot && !gnt_hits_empty;
        gnt_illegal    = gnt_any && (!gnt_onehot || gnt_hits_empty);
        out_free       = !out_valid_o || out_ready_i;
        // A legal grant against a full, stalled output is simply not taken.
        take           = gnt_legal && out_free;
        take_vec       = take ? gnt_i : '0;
        gnt_idx        = '0;
        gnt_data       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_i[i]) begin
                gnt_idx  = IDX_W'(i);
                gnt_data = slot_data[i];
            end
        end
    end

    // Slot occupancy: taken slots empty, empty slots fill on a valid input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~take_vec) | (in_valid_i & ~pend);
        end
    end

    // Slot payload registers load on capture; contents only matter while pending.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (in_valid_i[i] && !pend[i]) begin
                slot_data[i] <= in_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Output stage: load on a taken grant, drop valid once consumed, else hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_idx_o   <= '0;
        end else if (take) begin
            out_valid_o <= 1'b1;
            out_data_o  <= gnt_data;
            out_idx_o   <= gnt_idx;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

    // Grant error flag: one-cycle pulse after a multi-hot grant or a grant to an empty slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt_err_o <= 1'b0;
        end else begin
            gnt_err_o <= gnt_illegal;
        end
    end

`ifdef ARB_REQ_HOLDER_STARVE_MON_EN
    localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]   wait_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] starve;

    // Per-slot wait counters saturate at the limit; the flag clears the cycle after service.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
            starve <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] || take_vec[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != LIMIT) begin
                    wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
                end
                starve[i] <= pend[i] && !take_vec[i] && (wait_cnt[i] == LIMIT);
            end
        end
    end

    assign starve_o = starve;
`else
    assign starve_o = '0;
`endif

endmodule

// File: tb/tb_arb_req_holder.sv
// Testbench for arb_req_holder: directed scenarios plus randomized traffic
// against a cycle-level reference model. Starvation expectations follow
// ARB_REQ_HOLDER_STARVE_MON_EN.
module tb_arb_req_holder;
    localparam int NUM_REQ      = 4;
    localparam int DATA_W       = 8;
    localparam int STARVE_LIMIT = 15;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ*DATA_W-1:0] in_data;
    logic [NUM_REQ-1:0]        in_valid;
    logic [NUM_REQ-1:0]        in_ready;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         out_data;
    logic [1:0]                out_idx;
    logic                      out_valid;
    logic                      out_ready;
    logic                      gnt_err;
    logic [NUM_REQ-1:0]        starve;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    arb_req_holder #(
        .NUM_REQ(NUM_REQ),
        .DATA_W(DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .in_data_i(in_data),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .req_o(req),
        .gnt_i(gnt),
        .out_data_o(out_data),
        .out_idx_o(out_idx),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .gnt_err_o(gnt_err),
        .starve_o(starve)
    );

    // Reference model state
    bit               m_pend [NUM_REQ];
    logic [DATA_W-1:0] m_data [NUM_REQ];
    int               m_age  [NUM_REQ];
    bit               m_ov;
    logic [DATA_W-1:0] m_od;
    int               m_oi;
    bit               m_err;

    always @(posedge clk) begin : ref_model
        int ones;
        int sel;
        bit free;
        bit take;
        bit old_pend [NUM_REQ];
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                m_pend[i] = 1'b0;
                m_age[i]  = 0;
            end
            m_ov = 1'b0; m_od = '0; m_oi = 0; m_err = 1'b0;
        end else begin
            ones = $countones(gnt);
            sel  = 0;
            for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) sel = i;
            free  = !m_ov || out_ready;
            take  = 1'b0;
            m_err = 1'b0;
            if (ones > 1) m_err = 1'b1;
            else if (ones == 1) begin
                if (!m_pend[sel]) m_err = 1'b1;
                else if (free) take = 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++) old_pend[i] = m_pend[i];
            for (int i = 0; i < NUM_REQ; i++) begin
                if (old_pend[i] && !(take && sel == i)) m_age[i] = m_age[i] + 1;
                else m_age[i] = 0;
            end
            if (take) begin
                m_ov = 1'b1; m_od = m_data[sel]; m_oi = sel; m_pend[sel] = 1'b0;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (in_valid[i] && !old_pend[i]) begin
                    m_pend[i] = 1'b1;
                    m_data[i] = in_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    function automatic logic [NUM_REQ-1:0] model_pend();
        logic [NUM_REQ-1:0] v;
        for (int i = 0; i < NUM_REQ; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [NUM_REQ-1:0] model_starve();
        logic [NUM_REQ-1:0] v = '0;
`ifdef ARB_REQ_HOLDER_STARVE_MON_EN
        for (int i = 0; i < NUM_REQ; i++) v[i] = (m_age[i] >= STARVE_LIMIT + 1);
`endif
        return v;
    endfunction

    // Fixed-priority arbiter, LSB highest
    function automatic logic [NUM_REQ-1:0] lowest(input logic [NUM_REQ-1:0] r);
        logic [NUM_REQ-1:0] g = '0;
        for (int i = 0; i < NUM_REQ; i++) if (r[i] && g == '0) g[i] = 1'b1;
        return g;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (req !== 4'b0000) begin n_fail++; $display("FAIL rst_req: got %b expected 0000", req); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ov: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_od: got %h expected 00", out_data); end
        n_cmp++; if (out_idx !== 2'd0) begin n_fail++; $display("FAIL rst_oi: got %0d expected 0", out_idx); end
        n_cmp++; if (gnt_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", gnt_err); end
        n_cmp++; if (starve !== 4'b0000) begin n_fail++; $display("FAIL rst_starve: got %b expected 0000", starve); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 4'b1111) begin n_fail++; $display("FAIL rst_rdy: got %b expected 1111", in_ready); end
        // mid-transaction reset: slot 2 pending, output holding slot 0
        in_valid = 4'b0101; in_data = '0;
        in_data[0*DATA_W +: DATA_W] = 8'h55; in_data[2*DATA_W +: DATA_W] = 8'h22;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = '0; gnt = 4'b0001;
        @(negedge clk);
        gnt = '0;
        n_cmp++; if (req !== 4'b0100) begin n_fail++; $display("FAIL mid_req: got %b expected 0100", req); end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_ov: got %b expected 1", out_valid); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (req !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_req: got %b expected 0000", req); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ov: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_od: got %h expected 00", out_data); end
        @(negedge clk);
        n_cmp++; if (in_ready !== 4'b1111) begin n_fail++; $display("FAIL mid_rst_rdy: got %b expected 1111", in_ready); end
        out_ready = 1'b1;
    endtask

    task automatic test_single_path();
        in_valid = 4'b0010; in_data[1*DATA_W +: DATA_W] = 8'hA5;
        @(negedge clk);
        in_valid = '0;
        n_cmp++; if (req !== 4'b0010) begin n_fail++; $display("FAIL sp_req: got %b expected 0010", req); end
        n_cmp++; if (in_ready !== 4'b1101) begin n_fail++; $display("FAIL sp_rdy: got %b expected 1101", in_ready); end
        gnt = 4'b0010; out_ready = 1'b1;
        @(negedge clk);
        gnt = '0;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sp_ov: got %b expected 1", out_valid); end
        n_cmp++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL sp_od: got %h expected a5", out_data); end
        n_cmp++; if (out_idx !== 2'd1) begin n_fail++; $display("FAIL sp_oi: got %0d expected 1", out_idx); end
        n_cmp++; if (req[1] !== 1'b0) begin n_fail++; $display("FAIL sp_req1: got %b expected 0", req[1]); end
        @(negedge clk);
    endtask

    task automatic test_priority_drain();
        in_valid = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) in_data[i*DATA_W +: DATA_W] = 8'(16 + i);
        @(negedge clk);
        in_valid = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            gnt = lowest(req);
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pd_ov[%0d]: got %b expected 1", k, out_valid); end
            n_cmp++; if (out_idx !== 2'(k)) begin n_fail++; $display("FAIL pd_oi[%0d]: got %0d expected %0d", k, out_idx, k); end
            n_cmp++; if (out_data !== 8'(16 + k)) begin n_fail++; $display("FAIL pd_od[%0d]: got %h expected %h", k, out_data, 8'(16 + k)); end
        end
        gnt = '0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pd_end_ov: got %b expected 0", out_valid); end
        n_cmp++; if (req !== 4'b0000) begin n_fail++; $display("FAIL pd_end_req: got %b expected 0000", req); end
    endtask

    task automatic test_backpressure();
        in_valid = 4'b0101;
        in_data[0*DATA_W +: DATA_W] = 8'h3C; in_data[2*DATA_W +: DATA_W] = 8'hC3;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = '0; gnt = 4'b0001;
        @(negedge clk);
        n_cmp++; if (out_data !== 8'h3C) begin n_fail++; $display("FAIL bp_fill: got %h expected 3c", out_data); end
        gnt = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if (req[2] !== 1'b1) begin n_fail++; $display("FAIL bp_req2[%0d]: got %b expected 1", c, req[2]); end
            n_cmp++; if (out_data !== 8'h3C || out_idx !== 2'd0 || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v%b i%0d d%h expected v1 i0 d3c", c, out_valid, out_idx, out_data); end
            n_cmp++; if (gnt_err !== 1'b0) begin n_fail++; $display("FAIL bp_err[%0d]: got %b expected 0", c, gnt_err); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        gnt = '0;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hC3 || out_idx !== 2'd2) begin
            n_fail++; $display("FAIL bp_release: got v%b i%0d d%h expected v1 i2 dc3", out_valid, out_idx, out_data); end
        n_cmp++; if (req !== 4'b0000) begin n_fail++; $display("FAIL bp_req: got %b expected 0000", req); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_illegal_grant();
        in_valid = 4'b0011;
        in_data[0*DATA_W +: DATA_W] = 8'h7E; in_data[1*DATA_W +: DATA_W] = 8'h81;
        @(negedge clk);
        in_valid = '0; gnt = 4'b0011;
        @(negedge clk);
        gnt = '0;
        n_cmp++; if (gnt_err !== 1'b1) begin n_fail++; $display("FAIL ig_multi_err: got %b expected 1", gnt_err); end
        n_cmp++; if (req !== 4'b0011) begin n_fail++; $display("FAIL ig_multi_req: got %b expected 0011", req); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ig_multi_ov: got %b expected 0", out_valid); end
        @(negedge clk);
        n_cmp++; if (gnt_err !== 1'b0) begin n_fail++; $display("FAIL ig_multi_pulse: got %b expected 0", gnt_err); end
        gnt = 4'b0001; out_ready = 1'b0;
        @(negedge clk);
        gnt = 4'b1000;
        @(negedge clk);
        gnt = '0;
        n_cmp++; if (gnt_err !== 1'b1) begin n_fail++; $display("FAIL ig_empty_err: got %b expected 1", gnt_err); end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h7E || out_idx !== 2'd0) begin
            n_fail++; $display("FAIL ig_empty_out: got v%b i%0d d%h expected v1 i0 d7e", out_valid, out_idx, out_data); end
        n_cmp++; if (req !== 4'b0010) begin n_fail++; $display("FAIL ig_empty_req: got %b expected 0010", req); end
        @(negedge clk);
        n_cmp++; if (gnt_err !== 1'b0) begin n_fail++; $display("FAIL ig_empty_pulse: got %b expected 0", gnt_err); end
        out_ready = 1'b1; gnt = 4'b0010;
        @(negedge clk);
        gnt = '0;
        @(negedge clk);
    endtask

    task automatic test_starve();
        logic exp;
        in_valid = 4'b1000; in_data[3*DATA_W +: DATA_W] = 8'h5A;
        @(negedge clk);
        in_valid = '0;
        n_cmp++; if (req[3] !== 1'b1) begin n_fail++; $display("FAIL st_req3: got %b expected 1", req[3]); end
        for (int c = 1; c <= 20; c++) begin
`ifdef ARB_REQ_HOLDER_STARVE_MON_EN
            exp = (c >= STARVE_LIMIT + 2);
`else
            exp = 1'b0;
`endif
            n_cmp++; if (starve !== {exp, 3'b000}) begin
                n_fail++; $display("FAIL st_flag[%0d]: got %b expected %b", c, starve, {exp, 3'b000}); end
            @(negedge clk);
        end
        gnt = 4'b1000; out_ready = 1'b1;
        @(negedge clk);
        gnt = '0;
        n_cmp++; if (starve !== 4'b0000) begin n_fail++; $display("FAIL st_clear: got %b expected 0000", starve); end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h5A || out_idx !== 2'd3) begin
            n_fail++; $display("FAIL st_out: got v%b i%0d d%h expected v1 i3 d5a", out_valid, out_idx, out_data); end
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            n_cmp++; if (req !== model_pend()) begin n_fail++; $display("FAIL rnd_req[%0d]: got %b expected %b", c, req, model_pend()); end
            n_cmp++; if (in_ready !== ~model_pend()) begin n_fail++; $display("FAIL rnd_rdy[%0d]: got %b expected %b", c, in_ready, ~model_pend()); end
            n_cmp++; if (out_valid !== m_ov) begin n_fail++; $display("FAIL rnd_ov[%0d]: got %b expected %b", c, out_valid, m_ov); end
            n_cmp++; if (out_data !== m_od) begin n_fail++; $display("FAIL rnd_od[%0d]: got %h expected %h", c, out_data, m_od); end
            n_cmp++; if (out_idx !== 2'(m_oi)) begin n_fail++; $display("FAIL rnd_oi[%0d]: got %0d expected %0d", c, out_idx, m_oi); end
            n_cmp++; if (gnt_err !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b expected %b", c, gnt_err, m_err); end
            n_cmp++; if (starve !== model_starve()) begin n_fail++; $display("FAIL rnd_starve[%0d]: got %b expected %b", c, starve, model_starve()); end
            rst       = ($urandom_range(0, 79) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = 4'($urandom);
            in_data   = 32'($urandom);
            r = $urandom_range(0, 11);
            if (r == 0) gnt = 4'($urandom);
            else if (r == 1) gnt = '0;
            else if (r == 2) gnt = 4'b0001 << $urandom_range(0, 3);
            else if (r < 5) gnt = '0;
            else gnt = lowest(req);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = '0; gnt = '0; out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = '0; gnt = '0; out_ready = 1'b1;
        test_reset();
        test_single_path();
        test_priority_drain();
        test_backpressure();
        test_illegal_grant();
        test_starve();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
